// File: rtl/mem_pkg.sv
// Shared definitions for the burst main memory, the L2 in front of it and
// the bench: FSM state encoding and the default geometry/timing constants.
package mem_pkg;

    localparam int unsigned MEM_ADDR_W    = 11;
    localparam int unsigned MEM_DATA_W    = 32;
    localparam int unsigned MEM_BURST_LEN = 4;
    localparam int unsigned MEM_LATENCY   = 4;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RD_BURST,
        WR_WAIT
    } mem_state_e;

endpackage : mem_pkg

// File: rtl/mem_storage_array.sv
// DEPTH x DATA_W storage for the main memory model.
// Ports:
//   clk      - write clock
//   wr_en    - commit wr_data to wr_addr on the rising edge
//   wr_addr  - write word address
//   wr_data  - write data
//   rd_addr  - read word address (combinational read)
//   rd_data  - read data
// Contents power up as memory[i] = i and are never cleared by reset.
module mem_storage_array #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2048
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    typedef logic [DATA_W-1:0] mem_t [DEPTH];

    function automatic mem_t init_pattern();
        mem_t m;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            m[i] = DATA_W'(i);
        end
        return m;
    endfunction

    // Power-up image; no reset term so rst_n leaves the contents intact.
    mem_t mem_q = init_pattern();

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule : mem_storage_array

// File: rtl/burst_main_memory.sv
// Main memory model behind the L2: one outstanding request at a time, either
// a single-word write (acked after LATENCY cycles) or a line-fill read
// returned as a BURST_LEN-beat critical-word-first burst with valid/ready.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   req_valid/req_ready   - request handshake (ready only in IDLE)
//   req_write             - 1 = write one word, 0 = line-fill read
//   req_addr, req_wdata   - word address, write data
//   resp_valid/resp_ready - read beat handshake
//   resp_data, resp_last  - beat data, final-beat flag
//   wr_ack                - one-cycle pulse when a write commits
module burst_main_memory
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W    = MEM_ADDR_W,
    parameter int unsigned DATA_W    = MEM_DATA_W,
    parameter int unsigned DEPTH     = 2 ** MEM_ADDR_W,
    parameter int unsigned BURST_LEN = MEM_BURST_LEN,
    parameter int unsigned LATENCY   = MEM_LATENCY
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_last,
    output logic              wr_ack
);

    localparam int unsigned       CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned       BEAT_W    = 5;
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(LATENCY - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(BURST_LEN - 1);

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              resp_last_q, resp_last_d;
    logic              wr_ack_q, wr_ack_d;

    logic              accept;
    logic              beat_done;
    logic [BEAT_W-1:0] fetch_beat;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              mem_we;

    assign accept    = req_valid && (state_q == IDLE);
    assign beat_done = resp_valid_q && resp_ready;

    // Beat to fetch next: beat 0 while waiting, otherwise the one after the
    // beat currently presented. Offset wraps inside the line, base untouched.
    assign fetch_beat = (state_q == RD_BURST) ? beat_q + BEAT_W'(1) : '0;
    assign rd_addr    = (addr_q & ~LINE_MASK)
                      | ((addr_q + ADDR_W'(fetch_beat)) & LINE_MASK);

    // State-derived, so an asynchronous reset during WR_WAIT drops the write.
    assign mem_we = (state_q == WR_WAIT) && (cnt_q == '0);

    mem_storage_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_storage (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (addr_q),
        .wr_data (wdata_q),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // State register and datapath flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            beat_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_last_q  <= 1'b0;
            wr_ack_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            beat_q       <= beat_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_last_q  <= resp_last_d;
            wr_ack_q     <= wr_ack_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (accept) state_d = req_write ? WR_WAIT : RD_WAIT;
            RD_WAIT:  if (cnt_q == '0) state_d = RD_BURST;
            RD_BURST: if (beat_done && (beat_q == LAST_BEAT)) state_d = IDLE;
            WR_WAIT:  if (cnt_q == '0) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output and counter logic
    always_comb begin
        cnt_d        = cnt_q;
        beat_d       = beat_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_last_d  = resp_last_q;
        wr_ack_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_LOAD;
                    beat_d  = '0;
                end
            end
            RD_WAIT: begin
                if (cnt_q == '0) begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = rd_data;
                    resp_last_d  = (BURST_LEN == 1);
                    beat_d       = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RD_BURST: begin
                if (beat_done) begin
                    if (beat_q == LAST_BEAT) begin
                        resp_valid_d = 1'b0;
                        resp_data_d  = '0;
                        resp_last_d  = 1'b0;
                    end else begin
                        beat_d      = fetch_beat;
                        resp_data_d = rd_data;
                        resp_last_d = (fetch_beat == LAST_BEAT);
                    end
                end
            end
            WR_WAIT: begin
                if (cnt_q == '0) begin
                    wr_ack_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_last  = resp_last_q;
    assign wr_ack     = wr_ack_q;

endmodule : burst_main_memory

// File: tb/tb_burst_main_memory.sv
module tb_burst_main_memory;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [10:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic        resp_last;
    logic        wr_ack;

    int tests = 0;
    int fails = 0;
    int acc_cnt = 0;
    int acc_base;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && req_valid && req_ready) acc_cnt <= acc_cnt + 1;
    end

    burst_main_memory #(
        .ADDR_W    (11),
        .DATA_W    (32),
        .DEPTH     (2048),
        .BURST_LEN (4),
        .LATENCY   (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_last  (resp_last),
        .wr_ack     (wr_ack)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle. Presents a request, checks the
    // acceptance and the LATENCY=4 delay to the first beat / write ack.
    // Returns at the negedge where the first beat (or the ack) is visible
    // (for writes: one cycle later, after checking the pulse ended).
    task automatic issue(input bit wr, input logic [10:0] a, input logic [31:0] d,
                         input logic rr, input bit keep);
        check("ready_before_req", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = a;
        req_wdata  = d;
        resp_ready = rr;
        @(posedge clk);
        #1;
        if (!keep) req_valid = 1'b0;
        @(negedge clk);
        check("ready_after_accept", {31'b0, req_ready}, 32'd0);
        check("lat_c0", {31'b0, (wr ? wr_ack : resp_valid)}, 32'd0);
        for (int i = 1; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("lat_wait", {31'b0, (wr ? wr_ack : resp_valid)}, 32'd0);
        end
        @(posedge clk);
        @(negedge clk);
        check("lat_first", {31'b0, (wr ? wr_ack : resp_valid)}, 32'd1);
        if (wr) begin
            check("wr_ready_back", {31'b0, req_ready}, 32'd1);
            @(posedge clk);
            @(negedge clk);
            check("wr_ack_single", {31'b0, wr_ack}, 32'd0);
        end
    endtask

    // Called at a negedge. Checks each presented beat (including while
    // stalled) against the expected sequence; pat bit c drives resp_ready
    // for cycle c. Returns at the negedge after the nbeats-th completion.
    task automatic collect(input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3,
                           input int nbeats, input logic [15:0] pat, input bit vary);
        logic [31:0] exp_data [4];
        int idx;
        int c;
        exp_data[0] = e0; exp_data[1] = e1; exp_data[2] = e2; exp_data[3] = e3;
        idx = 0;
        c = 0;
        while (idx < nbeats && c < 64) begin
            if (resp_valid) begin
                check("beat_data", resp_data, exp_data[idx]);
                check("beat_last", {31'b0, resp_last}, {31'b0, (idx == 3)});
                if (resp_ready) idx++;
            end
            @(posedge clk);
            #1;
            c++;
            resp_ready = (c < 16) ? pat[c] : 1'b1;
            if (vary) req_addr = 11'h100 + 11'(c);
            @(negedge clk);
        end
        check("beats_done", idx, nbeats);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset asserted
        #1;
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
            check("post_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
            check("post_rst_resp_last", {31'b0, resp_last}, 32'd0);
            check("post_rst_wr_ack", {31'b0, wr_ack}, 32'd0);
            check("post_rst_resp_data", resp_data, 32'd0);
        end

        // Critical-word-first read, no backpressure
        issue(1'b0, 11'h006, 32'd0, 1'b1, 1'b0);
        collect(32'h6, 32'h7, 32'h4, 32'h5, 4, 16'hFFFF, 1'b0);
        check("rd6_ready_back", {31'b0, req_ready}, 32'd1);
        check("rd6_valid_low", {31'b0, resp_valid}, 32'd0);

        // Two stall windows: 0x10 held two cycles, 0x11 held two cycles
        issue(1'b0, 11'h010, 32'd0, 1'b0, 1'b0);
        collect(32'h10, 32'h11, 32'h12, 32'h13, 4, 16'hFFE4, 1'b0);
        check("rd10_ready_back", {31'b0, req_ready}, 32'd1);

        // Write top word, then read a line that wraps into it
        issue(1'b1, 11'h7FF, 32'hDEADBEEF, 1'b1, 1'b0);
        issue(1'b0, 11'h7FD, 32'd0, 1'b1, 1'b0);
        collect(32'h7FD, 32'h7FE, 32'hDEADBEEF, 32'h7FC, 4, 16'hFFFF, 1'b0);

        // Reset in the middle of a burst
        issue(1'b0, 11'h008, 32'd0, 1'b1, 1'b0);
        collect(32'h8, 32'h9, 32'hA, 32'hB, 2, 16'hFFFF, 1'b0);
        check("mid_valid_before_rst", {31'b0, resp_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'b0, resp_valid}, 32'd0);
        check("mid_rst_data", resp_data, 32'd0);
        check("mid_rst_last", {31'b0, resp_last}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", {31'b0, req_ready}, 32'd1);
        issue(1'b0, 11'h008, 32'd0, 1'b1, 1'b0);
        collect(32'h8, 32'h9, 32'hA, 32'hB, 4, 16'hFFFF, 1'b0);

        // req_valid held high with changing addresses during a burst
        acc_base = acc_cnt;
        issue(1'b0, 11'h020, 32'd0, 1'b1, 1'b1);
        collect(32'h20, 32'h21, 32'h22, 32'h23, 4, 16'hFFFF, 1'b1);
        check("held_one_accept", acc_cnt - acc_base, 32'd1);
        issue(1'b0, 11'h031, 32'd0, 1'b1, 1'b0);
        check("held_second_accept", acc_cnt - acc_base, 32'd2);
        collect(32'h31, 32'h32, 32'h33, 32'h30, 4, 16'hFFFF, 1'b0);
        check("held_final_ready", {31'b0, req_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_burst_main_memory

// File: doc/burst_main_memory.md
Name: burst_main_memory

Overview:
Parametrised successor to the single-word main memory model. It sits behind the L2 and services one outstanding request at a time: a single-word write, or a line-fill read returned as a BURST_LEN-beat burst in critical-word-first order. A programmable access latency and a valid/ready response handshake let the L2 exercise realistic miss timing and backpressure.

Parameters:
ADDR_W, 11, word address width
DATA_W, 32, data word width
DEPTH, 2048, number of words, must equal 2**ADDR_W
BURST_LEN, 4, beats per line fill; power of two, 1..16
LATENCY, 4, cycles from request acceptance to first response beat or write ack; must be >= 1

Ports:
clk  input  1  clock, all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request; high only in IDLE
req_write  input  1  1 = write one word, 0 = line-fill read
req_addr  input  ADDR_W  word address
req_wdata  input  DATA_W  write data
resp_valid  output  1  read beat valid
resp_ready  input  1  L2 accepts the beat
resp_data  output  DATA_W  read beat data
resp_last  output  1  final beat of a burst
wr_ack  output  1  one-cycle pulse when a write commits

Behaviour:
- Contents initialise to memory[i] = i. The rst_n signal does not clear the contents.
- Reset values: req_ready=1 once rst_n is high; resp_valid=0, resp_data=0, resp_last=0, wr_ack=0. The FSM goes to IDLE and the latency counter and beat counter are 0.
- Acceptance: a request is accepted on a rising edge where req_valid && req_ready. The block captures the address, the write data and the read/write type. req_ready drops the following cycle.
- FSM states: IDLE, RD_WAIT, RD_BURST, WR_WAIT.
- IDLE transitions: an accepted read goes to RD_WAIT; an accepted write goes to WR_WAIT. The latency counter loads LATENCY-1.
- RD_WAIT: the counter decrements each cycle. At 0 the FSM moves to RD_BURST and beat 0 is registered. resp_valid is first high exactly LATENCY cycles after the acceptance edge.
- Beat order is critical-word-first. Line base = req_addr with its low log2(BURST_LEN) bits cleared. Beat k address = base | ((req_addr + k) mod BURST_LEN). Address arithmetic is confined to the line, so there is no carry into the base bits. The top line wraps naturally within DEPTH.
- RD_BURST: a beat completes when resp_valid && resp_ready. Then the next beat's data is registered for the following cycle, with no bubble.
- While resp_ready is low, resp_data and resp_last hold stable.
- resp_last is high only on beat BURST_LEN-1. When that beat completes, the FSM returns to IDLE and req_ready=1 in the next cycle.
- WR_WAIT: the counter decrements to 0. In that final cycle the memory is written and wr_ack pulses for 1 cycle. The FSM then returns to IDLE.
- A write is not visible until its ack. No read overlaps it, because only one request is outstanding.
- req_valid while not in IDLE is ignored; it is not queued.
- BURST_LEN=1 degenerates to a single-beat read with resp_last=1.
- rst_n asserted mid-operation clears outputs asynchronously and aborts the burst. An unacknowledged write is dropped, and memory keeps its prior value.

Decomposition:
- Shared package mem_pkg holds the state enum (IDLE, RD_WAIT, RD_BURST, WR_WAIT) and the default ADDR_W, DATA_W, BURST_LEN and LATENCY constants, shared with the L2 and the bench.
- One sub-module, mem_storage_array: DEPTH x DATA_W storage with a synchronous write, a combinational read and the init pattern.
- Top level holds the FSM, the counters and the output registers.

Test Plan:
- Reset, and the 5 cycles after release: req_ready=1, resp_valid=0, resp_last=0, wr_ack=0, resp_data=0.
- Read 0x006, defaults, resp_ready=1: first resp_valid 4 cycles after acceptance. Beats 0x6, 0x7, 0x4, 0x5 on consecutive cycles, resp_last only on 0x5. req_ready=1 the next cycle.
- Read 0x010 with resp_ready low in two separate stall windows: resp_data=0x10, then 0x11, each held while stalled. The full sequence is 0x10, 0x11, 0x12, 0x13 with no beat lost or duplicated.
- Write 0x7FF=0xDEADBEEF: wr_ack pulses once, 4 cycles after acceptance. Then read 0x7FD: beats 0x7FD, 0x7FE, 0xDEADBEEF, 0x7FC.
- Read 0x008, then assert rst_n low after the 2nd beat: resp_valid drops immediately. After release, req_ready=1, and read 0x008 returns 0x8, 0x9, 0xA, 0xB.
- Hold req_valid high with varying addresses throughout a burst: exactly one acceptance per burst, and no acceptance while req_ready=0.
